// File: rtl/button_input_conditioner.sv
// Push-button conditioner: two-flop synchronizer, debounce FSM, press/release/long-press
// strobes and a wrapping press counter. Every output is registered.
module button_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16000,
    parameter int LONG_CYCLES     = 8000000,
    parameter int COUNT_WIDTH     = 16,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Button,
    input  logic                   Clear,
    output logic                   State,
    output logic                   Pressed,
    output logic                   Released,
    output logic                   LongPress,
    output logic [COUNT_WIDTH-1:0] PressCount
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(LONG_CYCLES);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
    localparam logic          IDLE_LVL  = ACTIVE_LOW;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_CHECK,
        PRESSED,
        RELEASE_CHECK
    } fsm_t;

    fsm_t             fsm;
    logic             btn_p0;
    logic             btn_p1;
    logic             s;
    logic [DW-1:0]    db_cnt;
    logic [HW-1:0]    hold_cnt;
    logic             fired;
    logic             long_hit;

    function automatic logic [HW-1:0] hold_sat_inc(input logic [HW-1:0] v);
        return (v == HOLD_LAST) ? v : v + 1'b1;
    endfunction

    // stage p0/p1: metastability synchronizer, idles at the released pin level
    always_ff @(posedge Clock) begin
        if (Reset) begin
            btn_p0 <= IDLE_LVL;
            btn_p1 <= IDLE_LVL;
        end else begin
            btn_p0 <= Button;
            btn_p1 <= btn_p0;
        end
    end

    assign s        = ACTIVE_LOW ? ~btn_p1 : btn_p1;
    assign long_hit = (hold_cnt == HOLD_LAST) && !fired;

    // stage p2: debounce FSM and registered outputs
    always_ff @(posedge Clock) begin
        if (Reset) begin
            fsm        <= RELEASED;
            db_cnt     <= '0;
            hold_cnt   <= '0;
            fired      <= 1'b0;
            State      <= 1'b0;
            Pressed    <= 1'b0;
            Released   <= 1'b0;
            LongPress  <= 1'b0;
            PressCount <= '0;
        end else begin
            Pressed   <= 1'b0;
            Released  <= 1'b0;
            LongPress <= 1'b0;
            if (Clear) begin
                PressCount <= '0;
            end

            case (fsm)
                RELEASED: begin
                    if (s) begin
                        fsm    <= PRESS_CHECK;
                        db_cnt <= '0;
                    end
                end

                PRESS_CHECK: begin
                    if (!s) begin
                        fsm    <= RELEASED;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        fsm        <= PRESSED;
                        db_cnt     <= '0;
                        hold_cnt   <= '0;
                        State      <= 1'b1;
                        Pressed    <= 1'b1;
                        // a coincident Clear still keeps this press
                        PressCount <= Clear ? COUNT_WIDTH'(1) : PressCount + 1'b1;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end

                PRESSED: begin
                    hold_cnt <= hold_sat_inc(hold_cnt);
                    if (long_hit) begin
                        LongPress <= 1'b1;
                        fired     <= 1'b1;
                    end
                    if (!s) begin
                        fsm    <= RELEASE_CHECK;
                        db_cnt <= '0;
                    end
                end

                RELEASE_CHECK: begin
                    hold_cnt <= hold_sat_inc(hold_cnt);
                    if (!s && db_cnt == DB_LAST) begin
                        fsm      <= RELEASED;
                        db_cnt   <= '0;
                        fired    <= 1'b0;
                        State    <= 1'b0;
                        Released <= 1'b1;
                    end else begin
                        // long press stays live while State is still high
                        if (long_hit) begin
                            LongPress <= 1'b1;
                            fired     <= 1'b1;
                        end
                        if (s) begin
                            fsm    <= PRESSED;
                            db_cnt <= '0;
                        end else begin
                            db_cnt <= db_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    fsm <= RELEASED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_input_conditioner.sv
// Scoreboard bench: each driven press/release pushes its expected strobe, cycle and count;
// a negedge monitor pops and compares every strobe the conditioner produces.
module tb_button_input_conditioner;

    localparam int DB = 4;
    localparam int LG = 20;
    localparam int CW = 4;
    localparam int LAT = 3 + DB;

    localparam int K_PRS  = 0;
    localparam int K_REL  = 1;
    localparam int K_LONG = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          Button;
    logic          Clear;
    logic          State;
    logic          Pressed;
    logic          Released;
    logic          LongPress;
    logic [CW-1:0] PressCount;

    typedef struct {
        int kind;
        int at;
        int cnt;
        int st;
    } ev_t;

    ev_t q[$];
    ev_t mon_e;
    int  mon_kind;
    int  cyc = 0;
    int  total = 0;
    int  bad = 0;
    int  exp_cnt = 0;

    button_input_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .LONG_CYCLES    (LG),
        .COUNT_WIDTH    (CW),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .Clock     (clk),
        .Reset     (rst),
        .Button    (Button),
        .Clear     (Clear),
        .State     (State),
        .Pressed   (Pressed),
        .Released  (Released),
        .LongPress (LongPress),
        .PressCount(PressCount)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input int kind, input int at, input int cnt, input int st);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        e.cnt  = cnt;
        e.st   = st;
        q.push_back(e);
    endtask

    task automatic press(input bool_long);
        Button  = 1'b0;
        exp_cnt = (exp_cnt + 1) % (1 << CW);
        expect_ev(K_PRS, cyc + LAT, exp_cnt, 1);
        if (bool_long) expect_ev(K_LONG, cyc + LAT + LG, exp_cnt, 1);
    endtask

    task automatic release_btn();
        Button = 1'b1;
        expect_ev(K_REL, cyc + LAT, exp_cnt, 0);
    endtask

    always @(negedge clk) begin
        if (Pressed === 1'b1 || Released === 1'b1 || LongPress === 1'b1) begin
            mon_kind = (Pressed === 1'b1) ? K_PRS : (Released === 1'b1) ? K_REL : K_LONG;
            chk("strobe_excl", 32'(int'(Pressed) + int'(Released) + int'(LongPress)), 32'd1);
            if (q.size() == 0) begin
                chk("unexpected_strobe", 32'(mon_kind), 32'd99);
            end else begin
                mon_e = q.pop_front();
                chk("ev_kind", 32'(mon_kind), 32'(mon_e.kind));
                chk("ev_cycle", 32'(cyc), 32'(mon_e.at));
                chk("ev_count", 32'(PressCount), 32'(mon_e.cnt));
                chk("ev_state", 32'(State), 32'(mon_e.st));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        Button = 1'b0;
        Clear  = 1'b0;

        // reset held with the button pressed
        step(1);
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("rst_outputs", 32'({State, Pressed, Released, LongPress, PressCount}), 32'd0);
        end
        rst     = 1'b0;
        exp_cnt = 1;
        expect_ev(K_PRS, cyc + LAT, 1, 1);
        step(10);
        chk("rst_count", 32'(PressCount), 32'd1);
        release_btn();
        step(12);

        // bounce on the way in, then a lone short glitch
        step(3);
        Button = 1'b0;
        step(3);
        Button = 1'b1;
        step(3);
        press(1'b0);
        step(12);
        release_btn();
        step(12);
        Button = 1'b0;
        step(3);
        Button = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(1);
            chk("glitch_state", 32'(State), 32'd0);
        end

        // long press, then a long hold with release bounces
        press(1'b1);
        step(30);
        release_btn();
        step(12);
        press(1'b1);
        step(12);
        Button = 1'b1;
        step(2);
        Button = 1'b0;
        step(18);
        Button = 1'b1;
        step(2);
        Button = 1'b0;
        step(6);
        chk("hold_state", 32'(State), 32'd1);
        release_btn();
        step(12);

        // counter wrap
        Clear = 1'b1;
        step(1);
        Clear   = 1'b0;
        exp_cnt = 0;
        chk("clear_start", 32'(PressCount), 32'd0);
        for (int i = 1; i <= 17; i++) begin
            press(1'b0);
            step(8);
            chk("wrap_count", 32'(PressCount), 32'(i % 16));
            release_btn();
            step(8);
        end

        // clear coincident with an accepted press, then clear alone
        Button  = 1'b0;
        exp_cnt = 1;
        expect_ev(K_PRS, cyc + LAT, 1, 1);
        step(LAT - 1);
        Clear = 1'b1;
        step(1);
        Clear = 1'b0;
        chk("clear_with_press", 32'(PressCount), 32'd1);
        release_btn();
        step(10);
        for (int i = 0; i < 4; i++) begin
            press(1'b0);
            step(8);
            release_btn();
            step(8);
        end
        chk("count_before_clear", 32'(PressCount), 32'd5);
        Clear = 1'b1;
        step(1);
        Clear   = 1'b0;
        exp_cnt = 0;
        chk("clear_alone", 32'(PressCount), 32'd0);

        // reset while pressed, pin still held
        press(1'b0);
        step(10);
        chk("pre_reset_state", 32'(State), 32'd1);
        rst = 1'b1;
        step(1);
        chk("mid_reset_outputs", 32'({State, Pressed, Released, LongPress, PressCount}), 32'd0);
        rst     = 1'b0;
        exp_cnt = 1;
        expect_ev(K_PRS, cyc + LAT, 1, 1);
        step(12);
        chk("after_reset_count", 32'(PressCount), 32'd1);
        release_btn();
        step(12);

        chk("pending_events", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_input_conditioner.md
# button_input_conditioner

Conditions one raw, asynchronous, bouncy push-button pin on the TinyFPGA BX into clean synchronous events for the QuSoC. It synchronizes the pin, debounces it, and produces a debounced level, one-cycle press/release/long-press strobes and a wrapping press counter. Where the LED path carries SoC state out to a pin, this block carries pin state into the SoC. It sits in the board top level beside the reset-hold counter, and its outputs drive SoC input registers.

## Interface
- DEBOUNCE_CYCLES, 16000: consecutive stable cycles needed to accept a level change (1 ms at 16 MHz); must be ≥2.
- LONG_CYCLES, 8000000: cycles of continuous debounced press before LongPress fires (0.5 s); must be > DEBOUNCE_CYCLES.
- COUNT_WIDTH, 16: width of PressCount.
- ACTIVE_LOW, 1: 1 means the pin reads 0 when pressed (pull-up board wiring).

- Clock  in  1  16 MHz system clock; sole clock; all logic on its rising edge.
- Reset  in  1  synchronous, active-high; driven from the same reset-hold logic as the SoC.
- Button  in  1  raw asynchronous pin.
- Clear  in  1  synchronous strobe; zeroes PressCount.
- State  out  1  debounced level; 1 = pressed.
- Pressed  out  1  one-cycle strobe on the accepted press.
- Released  out  1  one-cycle strobe on the accepted release.
- LongPress  out  1  one-cycle strobe, at most once per press.
- PressCount  out  COUNT_WIDTH  accepted presses, modulo 2^COUNT_WIDTH.

## Operation
- **Synchronizer:** two flops. Polarity correction is applied after the synchronizer, giving `s` (1 = pressed).
  - Both flops reset to the released level, so `s` = 0 during reset.
- **FSM states:** RELEASED, PRESS_CHECK, PRESSED, RELEASE_CHECK.
- **RELEASED:**
  - `s` = 1 → PRESS_CHECK, with the debounce counter cleared.
- **PRESS_CHECK:**
  - `s` = 0 → back to RELEASED. Any bounce restarts the count from zero.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES−1 while `s` = 1 → PRESSED. On that edge: State←1, Pressed←1, PressCount increments, hold counter cleared.
- **PRESSED:**
  - The hold counter increments each cycle and saturates.
  - When it reaches LONG_CYCLES−1: LongPress←1 for one cycle, and a fired flag blocks further long-press strobes for this press.
  - `s` = 0 → RELEASE_CHECK, with the debounce counter cleared.
- **RELEASE_CHECK:** the symmetric check on `s` = 0.
  - `s` = 1 → back to PRESSED. The hold counter and fired flag keep their values, so a bounce does not re-arm LongPress.
  - Acceptance → RELEASED: State←0, Released←1, fired flag cleared.
  - The hold counter keeps counting in RELEASE_CHECK. LongPress may fire there, since State is still 1.
- **PressCount:**
  - Wraps from all-ones to 0.
  - Clear alone sets it to 0.
  - Clear in the same cycle as an accepted press sets it to 1, so the press is not lost.
- **Strobes:** Pressed, Released and LongPress are mutually exclusive in any cycle by construction.
- **Debounce counter width:** clog2(DEBOUNCE_CYCLES). It never exceeds DEBOUNCE_CYCLES−1.

## Timing
- **Reset:** while Reset is high, every output is 0: State, Pressed, Released, LongPress, PressCount. The FSM is in RELEASED and all counters and flags are 0.
- **Reset mid-press:** returns everything to the reset values immediately on the next edge. No Released strobe is emitted.
- **Held across reset release:** if the pin is held pressed when Reset releases, it is treated as a new press. Pressed fires 2+DEBOUNCE_CYCLES cycles after the first non-reset edge.
- **Press latency:** pin change sampled at edge t → `s` changes at t+2 → State and Pressed at t+2+DEBOUNCE_CYCLES. Release uses the same figure.
- **LongPress:** asserted LONG_CYCLES cycles after the Pressed cycle.
- **Outputs:** all registered; no combinational path from inputs to outputs.
- **Glitch rejection:** a glitch shorter than DEBOUNCE_CYCLES synchronized cycles never changes State.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, LONG_CYCLES=20, COUNT_WIDTH=4, ACTIVE_LOW=1.
1. **Reset:** hold Reset 5 cycles with Button=0 (pressed) → all outputs 0 throughout. After release, Pressed pulses exactly once, 6 cycles after the first non-reset edge, and PressCount=1.
2. **Bounce rejection:** Button toggles 1,0,1,0 for 3 cycles each, then holds 0 → no strobe during the bouncing; exactly one Pressed, 6 cycles after the final fall. A 3-cycle low glitch alone → State stays 0.
3. **Long press:** hold pressed 30 cycles → LongPress pulses once, exactly 20 cycles after Pressed. Then release → Released 6 cycles after the pin rise. A 2-cycle release bounce inside the hold → no second LongPress.
4. **Wrap:** 17 clean presses → PressCount reads 15 after press 15, 0 after press 16, 1 after press 17.
5. **Clear:** Clear coincident with the Pressed cycle → PressCount=1. Clear alone at PressCount=5 → 0 next cycle.
6. **Reset mid-press:** assert Reset while in the PRESSED state → State=0 next edge and no Released strobe. With the pin still low after release → a fresh Pressed 6 cycles later.
